// File: rtl/apb4_splitter_wdt.sv
// APB4 1-to-NUM_SLV splitter with base/mask address decode and a per-transfer
// watchdog. Decode misses and stalled completers are terminated locally with
// PSLVERR, and a one-cycle error report (pulse, code, address) is raised.
module apb4_splitter_wdt #(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned NUM_SLV        = 4,
   parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_MASK = '0,
   parameter int unsigned TIMEOUT_CYC    = 256
) (
   input  logic                              pclk,
   input  logic                              preset,
   input  logic [APB_ADDR_WIDTH-1:0]         m_paddr,
   input  logic [2:0]                        m_pprot,
   input  logic                              m_psel,
   input  logic                              m_penable,
   input  logic                              m_pwrite,
   input  logic [APB_DATA_WIDTH-1:0]         m_pwdata,
   input  logic [APB_DATA_WIDTH/8-1:0]       m_pstrb,
   output logic                              m_pready,
   output logic [APB_DATA_WIDTH-1:0]         m_prdata,
   output logic                              m_pslverr,
   output logic [APB_ADDR_WIDTH-1:0]         s_paddr,
   output logic [2:0]                        s_pprot,
   output logic                              s_pwrite,
   output logic [APB_DATA_WIDTH-1:0]         s_pwdata,
   output logic [APB_DATA_WIDTH/8-1:0]       s_pstrb,
   output logic [NUM_SLV-1:0]                s_psel,
   output logic                              s_penable,
   input  logic [NUM_SLV-1:0]                s_pready,
   input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] s_prdata,
   input  logic [NUM_SLV-1:0]                s_pslverr,
   output logic                              err_pulse,
   output logic [1:0]                        err_code,
   output logic [APB_ADDR_WIDTH-1:0]         err_addr
);

   localparam int unsigned IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned WCW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WCW-1:0] WC_LAST = (TIMEOUT_CYC > 0) ? WCW'(TIMEOUT_CYC - 1) : '0;

   localparam logic [1:0] CODE_MISS    = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                    state_q, state_d;
   logic [IDXW-1:0]           sel_idx_q, sel_idx_d;
   logic                      hit_q, hit_d;
   logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
   logic                      err_pulse_q, err_pulse_d;
   logic [1:0]                err_code_q, err_code_d;
   logic [APB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic                      dec_hit;
   logic [IDXW-1:0]           dec_idx;
   logic                      wdt_expire;

   // Shared completer bus is a straight copy of the requester request lines
   assign s_paddr  = m_paddr;
   assign s_pprot  = m_pprot;
   assign s_pwrite = m_pwrite;
   assign s_pwdata = m_pwdata;
   assign s_pstrb  = m_pstrb;

   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;
   assign err_addr  = err_addr_q;

   // Window decode; scanning high to low lets the lowest matching index win
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int unsigned i = NUM_SLV; i > 0; i--) begin
         if ((m_paddr & SLV_MASK[(i-1)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) ==
             (SLV_BASE[(i-1)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &
              SLV_MASK[(i-1)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
            dec_hit = 1'b1;
            dec_idx = IDXW'(i - 1);
         end
      end
   end

   assign wdt_expire = (TIMEOUT_CYC != 0) && (wait_cnt_q == WC_LAST);

   // Next-state and output logic for the transfer FSM
   always_comb begin
      state_d     = state_q;
      sel_idx_d   = sel_idx_q;
      hit_d       = hit_q;
      wait_cnt_d  = wait_cnt_q;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      err_addr_d  = err_addr_q;
      s_psel      = '0;
      s_penable   = 1'b0;
      m_pready    = 1'b0;
      m_pslverr   = 1'b0;
      m_prdata    = '0;

      unique case (state_q)
         IDLE: begin
            if (m_psel && !m_penable) begin
               if (dec_hit) s_psel[dec_idx] = 1'b1;
               sel_idx_d  = dec_idx;
               hit_d      = dec_hit;
               wait_cnt_d = '0;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (!m_psel) begin
               // Requester abandoned the transfer: drop quietly
               state_d = IDLE;
            end else if (!hit_q) begin
               m_pready    = 1'b1;
               m_pslverr   = 1'b1;
               err_pulse_d = 1'b1;
               err_code_d  = CODE_MISS;
               err_addr_d  = m_paddr;
               state_d     = IDLE;
            end else begin
               s_psel[sel_idx_q] = 1'b1;
               s_penable         = m_penable;
               if (s_pready[sel_idx_q]) begin
                  // Ready takes priority over a watchdog expiring this cycle
                  m_pready  = 1'b1;
                  m_prdata  = s_prdata[sel_idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                  m_pslverr = s_pslverr[sel_idx_q];
                  state_d   = IDLE;
               end else if (wdt_expire) begin
                  m_pready    = 1'b1;
                  m_pslverr   = 1'b1;
                  err_pulse_d = 1'b1;
                  err_code_d  = CODE_TIMEOUT;
                  err_addr_d  = m_paddr;
                  state_d     = IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + WCW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and error-report registers
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= IDLE;
         sel_idx_q   <= '0;
         hit_q       <= 1'b0;
         wait_cnt_q  <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_idx_q   <= sel_idx_d;
         hit_q       <= hit_d;
         wait_cnt_q  <= wait_cnt_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
         err_addr_q  <= err_addr_d;
      end
   end

endmodule

// File: tb/tb_apb4_splitter_wdt.sv
// Directed bench for apb4_splitter_wdt: stimulus pushes expected responses
// into queues, a negedge monitor pops and compares whenever the DUT completes
// a transfer or raises an error pulse.
module tb_apb4_splitter_wdt;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam logic [NS*AW-1:0] BASE  = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
   localparam logic [NS*AW-1:0] MASK  = {32'hF000, 32'hF000, 32'hF000, 32'hF000};
   localparam logic [NS*AW-1:0] MASKO = {32'hF000, 32'hF000, 32'hF000, 32'h0000};

   logic            pclk = 1'b0;
   logic            preset;
   logic [AW-1:0]   m_paddr;
   logic [2:0]      m_pprot;
   logic            m_psel, m_penable, m_pwrite;
   logic [DW-1:0]   m_pwdata;
   logic [DW/8-1:0] m_pstrb;
   logic            m_pready, m_pslverr;
   logic [DW-1:0]   m_prdata;
   logic [AW-1:0]   s_paddr;
   logic [2:0]      s_pprot;
   logic            s_pwrite, s_penable;
   logic [DW-1:0]   s_pwdata;
   logic [DW/8-1:0] s_pstrb;
   logic [NS-1:0]   s_psel, s_pready, s_pslverr;
   logic [NS*DW-1:0] s_prdata;
   logic            err_pulse;
   logic [1:0]      err_code;
   logic [AW-1:0]   err_addr;

   // overlap instance outputs
   logic            o_pready, o_pslverr, o_penable, o_pwrite, o_err_pulse;
   logic [DW-1:0]   o_prdata, o_pwdata;
   logic [AW-1:0]   o_paddr, o_err_addr;
   logic [2:0]      o_pprot;
   logic [DW/8-1:0] o_pstrb;
   logic [NS-1:0]   o_psel;
   logic [1:0]      o_err_code;

   int checks = 0;
   int errors = 0;

   logic [DW:0]   exp_q[$];   // {pslverr, prdata}
   logic [AW+1:0] err_q[$];   // {code, addr}

   always #5 pclk = ~pclk;

   apb4_splitter_wdt #(
      .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_SLV(NS),
      .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(8)
   ) u_dut (
      .pclk(pclk), .preset(preset),
      .m_paddr(m_paddr), .m_pprot(m_pprot), .m_psel(m_psel), .m_penable(m_penable),
      .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
      .s_paddr(s_paddr), .s_pprot(s_pprot), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
      .s_pstrb(s_pstrb), .s_psel(s_psel), .s_penable(s_penable),
      .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
      .err_pulse(err_pulse), .err_code(err_code), .err_addr(err_addr)
   );

   // Window 0 covers the whole space, overlapping windows 1..3
   apb4_splitter_wdt #(
      .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_SLV(NS),
      .SLV_BASE(BASE), .SLV_MASK(MASKO), .TIMEOUT_CYC(8)
   ) u_ovl (
      .pclk(pclk), .preset(preset),
      .m_paddr(m_paddr), .m_pprot(m_pprot), .m_psel(m_psel), .m_penable(m_penable),
      .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_pready(o_pready), .m_prdata(o_prdata), .m_pslverr(o_pslverr),
      .s_paddr(o_paddr), .s_pprot(o_pprot), .s_pwrite(o_pwrite), .s_pwdata(o_pwdata),
      .s_pstrb(o_pstrb), .s_psel(o_psel), .s_penable(o_penable),
      .s_pready({NS{1'b1}}), .s_prdata(s_prdata), .s_pslverr({NS{1'b0}}),
      .err_pulse(o_err_pulse), .err_code(o_err_code), .err_addr(o_err_addr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every completion and every error pulse against the queues
   always @(negedge pclk) begin
      if (!preset) begin
         if (m_pready) begin
            if (exp_q.size() == 0) chk("unexpected_pready", 64'(m_pready), 64'd0);
            else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               chk("m_prdata", 64'(m_prdata), 64'(e[DW-1:0]));
               chk("m_pslverr", 64'(m_pslverr), 64'(e[DW]));
            end
         end
         if (err_pulse) begin
            if (err_q.size() == 0) chk("unexpected_err_pulse", 64'(err_pulse), 64'd0);
            else begin
               logic [AW+1:0] e;
               e = err_q.pop_front();
               chk("err_code", 64'(err_code), 64'(e[AW+1:AW]));
               chk("err_addr", 64'(err_addr), 64'(e[AW-1:0]));
            end
         end
      end
   end

   // One transfer, back-to-back with the previous one. slv<0 means no window.
   task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                       input int slv, input int nwait, input logic [DW-1:0] rdata,
                       input logic serr, input int exp_cyc, input logic exp_err,
                       input logic [1:0] exp_code);
      logic [NS-1:0] oh;
      int ncyc;
      oh = (slv >= 0) ? NS'(1 << slv) : '0;
      if (exp_err) begin
         exp_q.push_back({1'b1, {DW{1'b0}}});
         err_q.push_back({exp_code, addr});
      end else begin
         exp_q.push_back({serr, rdata});
      end
      @(posedge pclk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_paddr = addr; m_pwrite = wr;
      m_pwdata = wdata; m_pstrb = 4'hF; s_pready = '0; s_pslverr = '0;
      s_prdata = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
      if (slv >= 0) s_prdata[slv*DW +: DW] = rdata;
      @(negedge pclk);
      chk("setup_s_psel", 64'(s_psel), 64'(oh));
      chk("setup_m_pready", 64'(m_pready), 64'd0);
      chk("ovl_s_psel", 64'(o_psel), 64'd1);
      if (wr) chk("s_pwdata", 64'(s_pwdata), 64'(wdata));
      ncyc = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge pclk); #1;
         m_penable = 1'b1;
         s_pready  = (k == nwait) ? '1 : ~oh;
         s_pslverr = ~oh | (serr ? oh : '0);
         @(negedge pclk);
         ncyc++;
         chk("access_s_psel", 64'(s_psel), 64'(oh));
         if (m_pready) break;
      end
      chk("access_cycles", 64'(ncyc), 64'(exp_cyc));
   endtask

   task automatic idle_cycle();
      @(posedge pclk); #1;
      m_psel = 1'b0; m_penable = 1'b0; s_pready = '0;
      @(negedge pclk);
      chk("idle_s_psel", 64'(s_psel), 64'd0);
   endtask

   initial begin
      preset = 1'b1;
      m_paddr = '0; m_pprot = 3'b000; m_psel = 1'b0; m_penable = 1'b0;
      m_pwrite = 1'b0; m_pwdata = '0; m_pstrb = '0;
      s_pready = '0; s_prdata = '0; s_pslverr = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_s_psel", 64'(s_psel), 64'd0);
      chk("rst_m_pready", 64'(m_pready), 64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      chk("rst_err_code", 64'(err_code), 64'd0);
      chk("rst_err_addr", 64'(err_addr), 64'd0);
      preset = 1'b0;

      // zero-wait read of completer 1
      xfer(32'h1004, 1'b0, '0, 1, 0, 32'hCAFE0001, 1'b0, 1, 1'b0, 2'b00);
      // write with 3 wait states, back-to-back
      xfer(32'h2008, 1'b1, 32'h12345678, 2, 3, 32'h0, 1'b0, 4, 1'b0, 2'b00);
      // completer error passed through
      xfer(32'h0010, 1'b0, '0, 0, 1, 32'h0BAD0BAD, 1'b1, 2, 1'b0, 2'b00);
      idle_cycle();
      // decode miss
      xfer(32'h8000, 1'b0, '0, -1, 0, 32'h0, 1'b0, 1, 1'b1, 2'b01);
      idle_cycle();
      chk("miss_err_code_hold", 64'(err_code), 64'd1);
      // watchdog expiry on completer 3
      xfer(32'h3ABC, 1'b0, '0, 3, 99, 32'h33333333, 1'b0, 8, 1'b1, 2'b10);
      idle_cycle();
      chk("tmo_err_addr_hold", 64'(err_addr), 64'h3ABC);
      // ready in the expiry cycle: normal completion
      xfer(32'h3010, 1'b0, '0, 3, 7, 32'h33330008, 1'b0, 8, 1'b0, 2'b00);
      idle_cycle();

      // reset in the middle of a stalled transfer
      @(posedge pclk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h2000; s_pready = '0;
      @(posedge pclk); #1;
      m_penable = 1'b1;
      repeat (2) @(posedge pclk);
      #1 preset = 1'b1;
      #1;
      chk("rst_mid_s_psel", 64'(s_psel), 64'd0);
      chk("rst_mid_m_pready", 64'(m_pready), 64'd0);
      @(posedge pclk); #1;
      preset = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
      // next transfer decodes normally
      xfer(32'h1000, 1'b0, '0, 1, 0, 32'hCAFE0002, 1'b0, 1, 1'b0, 2'b00);
      idle_cycle();
      repeat (2) @(negedge pclk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("err_q_drained", 64'(err_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/apb4_splitter_wdt.md
Name: apb4_splitter_wdt

Overview:
- APB4 1-to-NUM_SLV splitter with a per-transfer watchdog. It sits between one APB4 requester and NUM_SLV APB4 completers.
- Address decode is parametrised by base/mask windows.
- An unmapped address, or a completer that stalls past TIMEOUT_CYC, is terminated locally with PSLVERR. This keeps the requester from hanging.
- A sticky-free error report (pulse, code, address) goes to the SoC error/IRQ logic.

Parameters:
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width (multiple of 8).
- NUM_SLV, 4, completer count (1..16).
- SLV_BASE, '0, packed NUM_SLV*APB_ADDR_WIDTH, base address of window i at slice i.
- SLV_MASK, '0, packed NUM_SLV*APB_ADDR_WIDTH. Window i hits when (paddr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYC, 256, maximum ACCESS cycles with pready low before abort. 0 disables the watchdog.

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous reset, active-high
- m_paddr  in  APB_ADDR_WIDTH  requester address
- m_pprot  in  3  protection
- m_psel  in  1  select
- m_penable  in  1  enable
- m_pwrite  in  1  write
- m_pwdata  in  APB_DATA_WIDTH  write data
- m_pstrb  in  APB_DATA_WIDTH/8  write strobes
- m_pready  out  1  ready to requester
- m_prdata  out  APB_DATA_WIDTH  read data to requester
- m_pslverr  out  1  error to requester
- s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb  out  (as m_*)  shared completer bus, direct copies of the m_* inputs
- s_psel  out  NUM_SLV  one-hot completer select
- s_penable  out  1  shared enable
- s_pready  in  NUM_SLV  completer ready
- s_prdata  in  NUM_SLV*APB_DATA_WIDTH  completer read data, slice i
- s_pslverr  in  NUM_SLV  completer error
- err_pulse  out  1  one-cycle error strobe
- err_code  out  2  01 = decode miss, 10 = timeout
- err_addr  out  APB_ADDR_WIDTH  address of the last errored transfer

Behaviour:
- FSM states: IDLE, ACCESS. Registers: state, sel_idx, hit, wait_cnt (width $clog2(TIMEOUT_CYC+1)), err_pulse, err_code, err_addr.
- Reset (async, preset=1): state=IDLE; sel_idx=0; hit=0; wait_cnt=0; err_pulse=0; err_code=0; err_addr=0. Combinational outputs evaluate as in IDLE: s_psel=0, s_penable=0, m_pready=0, m_pslverr=0, m_prdata=0.
- Decode is combinational on m_paddr. The lowest index among matching windows wins (priority on overlap).
- IDLE:
  - m_psel=1 and m_penable=0 is the setup phase.
  - On a hit, drive s_psel[idx]=1.
  - Latch sel_idx and hit, clear wait_cnt, go to ACCESS.
  - m_pready stays 0 during setup.
- ACCESS, hit=1:
  - s_psel[sel_idx]=1; s_penable=m_penable.
  - m_pready=s_pready[sel_idx]; m_prdata=s_prdata slice sel_idx; m_pslverr=s_pslverr[sel_idx].
  - When s_pready[sel_idx]=1, go to IDLE (zero-wait transfers take 2 cycles total).
  - Otherwise wait_cnt increments each cycle.
- Timeout: in ACCESS with TIMEOUT_CYC!=0, when wait_cnt==TIMEOUT_CYC-1 and s_pready[sel_idx]=0:
  - m_pready=1, m_pslverr=1, m_prdata=0.
  - s_psel is dropped the next cycle; the completer is abandoned.
  - err_pulse=1 next cycle, err_code=10, err_addr=m_paddr.
  - Go to IDLE.
- ACCESS, hit=0 (decode miss):
  - No s_psel asserted.
  - m_pready=1, m_pslverr=1, m_prdata=0 in the first ACCESS cycle.
  - err_pulse=1 next cycle, err_code=01, err_addr=m_paddr.
  - Go to IDLE.
- Boundary rules:
  - Completer ready in the same cycle the watchdog expires: normal completion wins, no error reported.
  - m_paddr changing during ACCESS does not re-decode; sel_idx stays latched.
  - err_pulse lasts exactly one cycle per error. err_code and err_addr hold until the next error.
  - A back-to-back setup phase in the cycle after completion is accepted from IDLE normally.
  - m_psel deasserted while in ACCESS (protocol violation): return to IDLE, report no error.
  - preset mid-transfer: immediate IDLE, all selects low, no error pulse.

Test Plan:
- Windows base 0x0000/0x1000/0x2000/0x3000, mask 0xF000. Read 0x1004, s_pready[1]=1 at once, s_prdata[1]=0xCAFE0001 -> s_psel=0010 for 2 cycles; m_prdata=0xCAFE0001; m_pready high in cycle 2; err_pulse=0.
- Write 0x2008, data 0x12345678, strb 0xF, completer 2 holds pready low 3 cycles -> m_pready=0 for 3 ACCESS cycles then 1; s_pwdata=0x12345678; m_pslverr follows s_pslverr[2]=0.
- Read 0x8000 (no window) -> s_psel stays 0000; m_pready=1 and m_pslverr=1 in the first ACCESS cycle; m_prdata=0; err_pulse one cycle; err_code=01; err_addr=0x8000.
- TIMEOUT_CYC=8, completer 3 never ready -> exactly 8 ACCESS cycles, then m_pready=1 and m_pslverr=1; err_code=10; err_addr=0x3xxx; s_psel=0000 afterwards. Variant with s_pready in cycle 8 -> normal completion, no error.
- Overlap: window 0 mask 0x0000 (matches all) plus window 1 -> access 0x1000 selects slave 0.
- Assert preset during ACCESS with 2 waits elapsed -> s_psel=0 and m_pready=0 immediately; the next transfer decodes correctly.
